// File: rtl/rvsteel_spi_target_pkg.sv
// Shared constants for the RISC-V Steel SPI target.
// Register offsets, STATUS bit positions, FSM encodings and the idle read value.
package rvsteel_spi_target_pkg;

    localparam logic [4:0] REG_CPOL       = 5'h00;
    localparam logic [4:0] REG_CPHA       = 5'h04;
    localparam logic [4:0] REG_WDATA      = 5'h08;
    localparam logic [4:0] REG_RDATA      = 5'h0c;
    localparam logic [4:0] REG_STATUS     = 5'h10;
    localparam logic [4:0] REG_IRQ_ENABLE = 5'h14;

    localparam int STATUS_RX_VALID = 0;
    localparam int STATUS_TX_FULL  = 1;
    localparam int STATUS_OVERRUN  = 2;
    localparam int STATUS_SELECTED = 3;

    localparam logic [2:0] ST_IDLE  = 3'b001;
    localparam logic [2:0] ST_LOAD  = 3'b010;
    localparam logic [2:0] ST_SHIFT = 3'b100;

    localparam logic [31:0] READ_DEFAULT = 32'hdeadbeef;

    function automatic logic [31:0] status_word(
        input logic rx_valid,
        input logic tx_full,
        input logic overrun,
        input logic selected
    );
        logic [31:0] w;
        w = 32'b0;
        w[STATUS_RX_VALID] = rx_valid;
        w[STATUS_TX_FULL]  = tx_full;
        w[STATUS_OVERRUN]  = overrun;
        w[STATUS_SELECTED] = selected;
        return w;
    endfunction

endpackage

// File: rtl/rvsteel_spi_target_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pad input.
// RESET_VALUE is the level presented while reset is asserted.
module rvsteel_spi_target_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_stages;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stages <= {SYNC_STAGES{RESET_VALUE}};
        end else begin
            r_stages <= {r_stages[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_stages[SYNC_STAGES-1];

endmodule

// File: rtl/rvsteel_spi_target.sv
// SPI target for RISC-V Steel: oversampled SCLK/PICO/CS, 8-bit MSB-first frames.
// Define RVSTEEL_SPI_TARGET_IRQ_EN to add the irq output and IRQ_ENABLE register.
module rvsteel_spi_target
    import rvsteel_spi_target_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  rw_address,
    output logic [31:0] read_data,
    input  logic        read_request,
    output logic        read_response,
    input  logic [7:0]  write_data,
    input  logic [3:0]  write_strobe,
    input  logic        write_request,
    output logic        write_response,
    input  logic        sclk,
    input  logic        pico,
    input  logic        cs,
    output logic        poci,
    output logic        poci_oe
`ifdef RVSTEEL_SPI_TARGET_IRQ_EN
    ,
    output logic        irq
`endif
);

    logic w_sclk_sync;
    logic w_pico_sync;
    logic w_cs_sync;

    rvsteel_spi_target_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_sclk (
        .clock   (clock),
        .reset   (reset),
        .i_async (sclk),
        .o_sync  (w_sclk_sync)
    );

    rvsteel_spi_target_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_pico (
        .clock   (clock),
        .reset   (reset),
        .i_async (pico),
        .o_sync  (w_pico_sync)
    );

    rvsteel_spi_target_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_cs (
        .clock   (clock),
        .reset   (reset),
        .i_async (cs),
        .o_sync  (w_cs_sync)
    );

    logic       r_cpol;
    logic       r_cpha;
    logic [7:0] r_tx_data;
    logic       r_tx_full;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_overrun;
    logic       r_sclk_prev;
    logic [2:0] r_state;
    logic [2:0] r_bit_count;
    logic [7:0] r_shift_tx;
    logic [7:0] r_shift_rx;
    logic       r_poci;

    logic       w_edge;
    logic       w_leading;
    logic       w_trailing;
    logic       w_in_shift;
    logic       w_sample;
    logic       w_shift_out;
    logic       w_byte_done;
    logic       w_load;
    logic [7:0] w_load_byte;
    logic       w_wr_en;
    logic       w_rd_rdata;
    logic [31:0] w_read_mux;

    assign w_edge     = w_sclk_sync ^ r_sclk_prev;
    assign w_leading  = w_edge & (w_sclk_sync != r_cpol);
    assign w_trailing = w_edge & (w_sclk_sync == r_cpol);
    assign w_in_shift = (r_state == ST_SHIFT) & ~w_cs_sync;
    assign w_sample   = w_in_shift & (r_cpha ? w_trailing : w_leading);

    // Mode 0 skips the trailing edge that follows a byte's last sample.
    assign w_shift_out = w_in_shift &
                         (r_cpha ? w_leading : (w_trailing & (r_bit_count != 3'd0)));

    assign w_byte_done = w_sample & (r_bit_count == 3'd7);
    assign w_load      = (r_state == ST_LOAD) & ~w_cs_sync;
    assign w_load_byte = r_tx_full ? r_tx_data : 8'hff;
    assign w_wr_en     = write_request & (&write_strobe);
    assign w_rd_rdata  = read_request & (rw_address == REG_RDATA);

    assign poci    = r_poci;
    assign poci_oe = ~w_cs_sync;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sclk_prev <= 1'b0;
            r_state     <= ST_IDLE;
            r_bit_count <= 3'd0;
            r_shift_tx  <= 8'hff;
            r_shift_rx  <= 8'h00;
            r_poci      <= 1'b1;
        end else begin
            r_sclk_prev <= w_sclk_sync;
            if (w_cs_sync) begin
                r_state     <= ST_IDLE;
                r_bit_count <= 3'd0;
                r_poci      <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_bit_count <= 3'd0;
                        r_state     <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        r_shift_tx  <= w_load_byte;
                        r_bit_count <= 3'd0;
                        if (!r_cpha) begin
                            r_poci <= w_load_byte[7];
                        end
                        r_state <= ST_SHIFT;
                    end
                    ST_SHIFT: begin
                        if (w_sample) begin
                            r_shift_rx  <= {r_shift_rx[6:0], w_pico_sync};
                            r_bit_count <= r_bit_count + 3'd1;
                            if (r_bit_count == 3'd7) begin
                                r_state <= ST_LOAD;
                            end
                        end
                        if (w_shift_out) begin
                            r_poci     <= r_cpha ? r_shift_tx[7] : r_shift_tx[6];
                            r_shift_tx <= {r_shift_tx[6:0], 1'b1};
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef RVSTEEL_SPI_TARGET_IRQ_EN
    logic [2:0] r_irq_enable;
    logic       r_irq;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_irq_enable <= 3'b000;
            r_irq        <= 1'b0;
        end else begin
            if (w_wr_en && rw_address == REG_IRQ_ENABLE) begin
                r_irq_enable <= write_data[2:0];
            end
            r_irq <= |(r_irq_enable & {r_overrun, ~r_tx_full, r_rx_valid});
        end
    end

    assign irq = r_irq;
`endif

    always_comb begin
        w_read_mux = READ_DEFAULT;
        case (rw_address)
            REG_CPOL:   w_read_mux = {31'b0, r_cpol};
            REG_CPHA:   w_read_mux = {31'b0, r_cpha};
            REG_WDATA:  w_read_mux = {24'b0, r_tx_data};
            REG_RDATA:  w_read_mux = {24'b0, r_rx_data};
            REG_STATUS: w_read_mux = status_word(r_rx_valid, r_tx_full,
                                                 r_overrun, ~w_cs_sync);
`ifdef RVSTEEL_SPI_TARGET_IRQ_EN
            REG_IRQ_ENABLE: w_read_mux = {29'b0, r_irq_enable};
`endif
            default:    w_read_mux = READ_DEFAULT;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            read_data      <= READ_DEFAULT;
            read_response  <= 1'b0;
            write_response <= 1'b0;
            r_cpol         <= 1'b0;
            r_cpha         <= 1'b0;
            r_tx_data      <= 8'hff;
            r_tx_full      <= 1'b0;
            r_rx_data      <= 8'h00;
            r_rx_valid     <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            read_response  <= read_request;
            write_response <= write_request;
            read_data      <= read_request ? w_read_mux : READ_DEFAULT;

            if (w_wr_en && w_cs_sync && rw_address == REG_CPOL) begin
                r_cpol <= write_data[0];
            end
            if (w_wr_en && w_cs_sync && rw_address == REG_CPHA) begin
                r_cpha <= write_data[0];
            end

            // A WDATA write wins over the LOAD that consumes the old byte.
            if (w_wr_en && rw_address == REG_WDATA) begin
                r_tx_data <= write_data;
                r_tx_full <= 1'b1;
            end else if (w_load) begin
                r_tx_full <= 1'b0;
            end

            if (w_byte_done) begin
                r_rx_data  <= {r_shift_rx[6:0], w_pico_sync};
                r_rx_valid <= 1'b1;
            end else if (w_rd_rdata) begin
                r_rx_valid <= 1'b0;
            end

            if (w_byte_done && r_rx_valid) begin
                r_overrun <= 1'b1;
            end else if (w_wr_en && rw_address == REG_STATUS &&
                         write_data[STATUS_OVERRUN]) begin
                r_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rvsteel_spi_target.sv
// Scoreboard bench for rvsteel_spi_target: a bus-level model predicts
// register reads and POCI bytes while a controller drives random SPI traffic.
module tb_rvsteel_spi_target;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  rw_address = 5'h0;
    logic [31:0] read_data;
    logic        read_request = 1'b0;
    logic        read_response;
    logic [7:0]  write_data = 8'h0;
    logic [3:0]  write_strobe = 4'h0;
    logic        write_request = 1'b0;
    logic        write_response;
    logic        sclk = 1'b0;
    logic        pico = 1'b0;
    logic        cs = 1'b1;
    logic        poci;
    logic        poci_oe;
`ifdef RVSTEEL_SPI_TARGET_IRQ_EN
    logic        irq;
`endif

    rvsteel_spi_target #(.SYNC_STAGES(2)) dut (
        .clock          (clock),
        .reset          (reset),
        .rw_address     (rw_address),
        .read_data      (read_data),
        .read_request   (read_request),
        .read_response  (read_response),
        .write_data     (write_data),
        .write_strobe   (write_strobe),
        .write_request  (write_request),
        .write_response (write_response),
        .sclk           (sclk),
        .pico           (pico),
        .cs             (cs),
        .poci           (poci),
        .poci_oe        (poci_oe)
`ifdef RVSTEEL_SPI_TARGET_IRQ_EN
        ,
        .irq            (irq)
`endif
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } exp_t;
    exp_t sb[$];

    // Reference model state
    logic       m_cpol, m_cpha, m_sel;
    logic [7:0] m_tx_data, m_rx_data, cur_tx;
    logic       m_tx_full, m_rx_valid, m_ovr;
    logic [2:0] m_irq_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cpol = 0; m_cpha = 0; m_sel = 0;
        m_tx_data = 8'hff; m_tx_full = 0;
        m_rx_data = 8'h00; m_rx_valid = 0; m_ovr = 0;
        m_irq_en = 3'b000; cur_tx = 8'hff;
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        case (a)
            5'h00: return {31'b0, m_cpol};
            5'h04: return {31'b0, m_cpha};
            5'h08: return {24'b0, m_tx_data};
            5'h0c: return {24'b0, m_rx_data};
            5'h10: return {28'b0, m_sel, m_ovr, m_tx_full, m_rx_valid};
`ifdef RVSTEEL_SPI_TARGET_IRQ_EN
            5'h14: return {29'b0, m_irq_en};
`endif
            default: return 32'hdeadbeef;
        endcase
    endfunction

    // Monitor: compare every read response against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (read_response) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_read: got %h expected no response", read_data);
                end else begin
                    e = sb.pop_front();
                    chk(e.name, read_data, e.exp);
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic read_reg(input logic [4:0] a, input string nm);
        exp_t e;
        @(negedge clock);
        rw_address = a;
        read_request = 1'b1;
        e.exp = exp_read(a);
        e.name = nm;
        sb.push_back(e);
        if (a == 5'h0c) m_rx_valid = 0;
        @(negedge clock);
        read_request = 1'b0;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [7:0] d, input logic [3:0] s);
        @(negedge clock);
        rw_address = a;
        write_data = d;
        write_strobe = s;
        write_request = 1'b1;
        if (s == 4'hf) begin
            case (a)
                5'h00: if (!m_sel) m_cpol = d[0];
                5'h04: if (!m_sel) m_cpha = d[0];
                5'h08: begin m_tx_data = d; m_tx_full = 1; end
                5'h10: if (d[2]) m_ovr = 0;
`ifdef RVSTEEL_SPI_TARGET_IRQ_EN
                5'h14: m_irq_en = d[2:0];
`endif
                default: ;
            endcase
        end
        @(negedge clock);
        write_request = 1'b0;
        write_strobe = 4'h0;
        chk("write_response", {31'b0, write_response}, 32'd1);
    endtask

    function automatic logic [7:0] model_load();
        logic [7:0] v;
        v = m_tx_full ? m_tx_data : 8'hff;
        m_tx_full = 0;
        return v;
    endfunction

    task automatic half();
        repeat (4) @(negedge clock);
    endtask

    task automatic cs_assert();
        sclk = m_cpol;
        repeat (2) @(negedge clock);
        cs = 1'b0;
        cur_tx = model_load();
        repeat (8) @(negedge clock);
        m_sel = 1;
    endtask

    task automatic cs_release();
        repeat (6) @(negedge clock);
        cs = 1'b1;
        repeat (6) @(negedge clock);
        m_sel = 0;
        sclk = m_cpol;
        repeat (2) @(negedge clock);
    endtask

    task automatic spi_byte(input logic [7:0] b);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            if (!m_cpha) begin
                pico = b[i];
                half();
                sclk = ~m_cpol;
                r[i] = poci;
                half();
                sclk = m_cpol;
            end else begin
                sclk = ~m_cpol;
                pico = b[i];
                half();
                sclk = m_cpol;
                r[i] = poci;
                half();
            end
        end
        chk("poci_byte", {24'b0, r}, {24'b0, cur_tx});
        if (m_rx_valid) m_ovr = 1;
        m_rx_data = b;
        m_rx_valid = 1;
        cur_tx = model_load();
        repeat (6) @(negedge clock);
    endtask

    task automatic partial_edges(input int n);
        for (int k = 0; k < n; k++) begin
            pico = 1'($urandom);
            half();
            sclk = ~sclk;
        end
        half();
    endtask

    task automatic set_mode(input logic p, input logic h);
        write_reg(5'h00, {7'b0, p}, 4'hf);
        write_reg(5'h04, {7'b0, h}, 4'hf);
        sclk = m_cpol;
        repeat (4) @(negedge clock);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clock);
        chk("rst_read_data", read_data, 32'hdeadbeef);
        chk("rst_read_response", {31'b0, read_response}, 32'd0);
        chk("rst_write_response", {31'b0, write_response}, 32'd0);
        chk("rst_poci", {31'b0, poci}, 32'd1);
        chk("rst_poci_oe", {31'b0, poci_oe}, 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clock);

        read_reg(5'h10, "status_reset");
        read_reg(5'h08, "wdata_reset");
        read_reg(5'h0c, "rdata_reset");

        // Mode 0 directed transfer
        write_reg(5'h08, 8'ha5, 4'hf);
        cs_assert();
        chk("poci_oe_selected", {31'b0, poci_oe}, 32'd1);
        spi_byte(8'h3c);
        read_reg(5'h10, "status_cs_low");
        cs_release();
        read_reg(5'h10, "status_cs_high");
        read_reg(5'h0c, "rdata_3c");
        read_reg(5'h10, "status_after_read");

        // Mode 3, nothing queued to send
        set_mode(1'b1, 1'b1);
        cs_assert();
        spi_byte(8'h81);
        cs_release();
        read_reg(5'h0c, "rdata_81");

        // Overrun across back-to-back bytes
        set_mode(1'b0, 1'b0);
        cs_assert();
        spi_byte(8'h11);
        spi_byte(8'h22);
        cs_release();
        read_reg(5'h10, "status_overrun");
        read_reg(5'h0c, "rdata_22");
        write_reg(5'h10, 8'h04, 4'hf);
        read_reg(5'h10, "status_ovr_cleared");

        // Partial byte discarded on cs rise
        cs_assert();
        partial_edges(5);
        cs_release();
        read_reg(5'h10, "status_after_partial");
        cs_assert();
        spi_byte(8'h5a);
        cs_release();
        read_reg(5'h10, "status_5a");
        read_reg(5'h0c, "rdata_5a");

        // CPOL write gating, strobes and unmapped offsets
        cs_assert();
        write_reg(5'h00, 8'h01, 4'hf);
        read_reg(5'h00, "cpol_locked");
        cs_release();
        write_reg(5'h00, 8'h01, 4'h7);
        read_reg(5'h00, "cpol_partial_strobe");
        write_reg(5'h00, 8'h01, 4'hf);
        read_reg(5'h00, "cpol_set");
        write_reg(5'h00, 8'h00, 4'hf);
        sclk = 1'b0;
        read_reg(5'h1c, "unmapped_1c");
        read_reg(5'h14, "offset_14");

        // Randomized sessions
        for (int s = 0; s < 24; s++) begin
            set_mode(1'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) write_reg(5'h08, 8'($urandom), 4'hf);
            cs_assert();
            for (int b = 0; b < int'($urandom_range(1, 3)); b++) begin
                spi_byte(8'($urandom));
                case ($urandom_range(0, 3))
                    0: read_reg(5'h0c, "rnd_rdata_in");
                    1: read_reg(5'h10, "rnd_status_in");
                    2: write_reg(5'h08, 8'($urandom), 4'hf);
                    default: ;
                endcase
            end
            cs_release();
            read_reg(5'h10, "rnd_status");
            if ($urandom_range(0, 1) == 1) read_reg(5'h0c, "rnd_rdata");
            if ($urandom_range(0, 2) == 0) write_reg(5'h10, 8'h04, 4'hf);
            read_reg(5'h08, "rnd_wdata");
        end

        // Reset in the middle of a byte
        set_mode(1'b0, 1'b0);
        write_reg(5'h08, 8'h3e, 4'hf);
        cs_assert();
        partial_edges(3);
        reset = 1'b0;
        @(negedge clock);
        chk("midrst_poci_oe", {31'b0, poci_oe}, 32'd0);
        chk("midrst_poci", {31'b0, poci}, 32'd1);
        cs = 1'b1;
        sclk = 1'b0;
        model_reset();
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        read_reg(5'h10, "midrst_status");
        read_reg(5'h08, "midrst_wdata");

        repeat (5) @(negedge clock);
        chk("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
